// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit iterative restoring divider (DIV/DIVU) with annul and divide-by-zero handling
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             annul,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] quo;        // dividend magnitude shifting out, quotient bits shifting in
   logic [WIDTH-1:0] dvs;        // divisor magnitude
   logic [WIDTH-1:0] rem;        // partial remainder, always < dvs between steps
   logic [5:0]       cnt;
   logic             neg_q;
   logic             neg_r;

   logic [WIDTH-1:0] opa_mag;
   logic [WIDTH-1:0] opb_mag;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             fits;

   assign busy = (state == CALC) || (state == FIX);
   assign done = (state == DONE);

   // Operand magnitudes; negating 0x80000000 yields 0x80000000, read as unsigned 2^31
   always_comb begin
      opa_mag = (signed_div && opa[WIDTH-1]) ? -opa : opa;
      opb_mag = (signed_div && opb[WIDTH-1]) ? -opb : opb;
   end

   // One restoring step: the shifted remainder needs 33 bits; when it fits, the
   // true difference is below dvs, so its low 32 bits are the whole result
   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      fits   = (rem_sh >= {1'b0, dvs});
      diff   = rem_sh[WIDTH-1:0] - dvs;
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         quo         <= '0;
         dvs         <= '0;
         rem         <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         lo          <= '0;
         hi          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (annul) begin
                  state <= IDLE;
               end else if (start) begin
                  if (opb == '0) begin
                     lo          <= '1;
                     hi          <= opa;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     quo   <= opa_mag;
                     dvs   <= opb_mag;
                     rem   <= '0;
                     cnt   <= '0;
                     neg_q <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                     neg_r <= signed_div && opa[WIDTH-1];
                     state <= CALC;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               if (annul) begin
                  state <= IDLE;
               end else begin
                  rem <= fits ? diff : rem_sh[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], fits};
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'(WIDTH - 1)) begin
                     state <= FIX;
                  end
               end
            end
            FIX: begin
               if (annul) begin
                  state <= IDLE;
               end else begin
                  lo          <= neg_q ? -quo : quo;
                  hi          <= neg_r ? -rem : rem;
                  div_by_zero <= 1'b0;
                  state       <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit with arithmetic reference model
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        signed_div = 1'b0;
   logic        annul = 1'b0;
   logic [31:0] opa = '0;
   logic [31:0] opb = '0;
   logic        busy;
   logic        done;
   logic [31:0] lo;
   logic [31:0] hi;
   logic        div_by_zero;

   int tests = 0;
   int fails = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
      .opa(opa), .opb(opb), .annul(annul), .busy(busy), .done(done),
      .lo(lo), .hi(hi), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference quotient/remainder by plain 64-bit arithmetic (truncating division)
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] q, output logic [31:0] r);
      longint la, lb, lq, lr;
      if (s) begin
         la = longint'($signed(a));
         lb = longint'($signed(b));
      end else begin
         la = longint'({32'b0, a});
         lb = longint'({32'b0, b});
      end
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
   endfunction

   // Model: m_t = cycles since accepted start (0 idle, 1..33 busy, 34 done)
   int          m_t = 0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_dbz = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = 0; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      end else if (annul) begin
         m_t = 0;
      end else if (start && (m_t == 0 || m_t == 34)) begin
         if (opb == 32'd0) begin
            m_t = 34; m_hi = opa; m_lo = '1; m_dbz = 1'b1;
         end else begin
            ref_div(opa, opb, signed_div, p_lo, p_hi);
            m_t = 1;
         end
      end else if (m_t == 34) begin
         m_t = 0;
      end else if (m_t > 0) begin
         m_t++;
         if (m_t == 34) begin
            m_hi = p_hi; m_lo = p_lo; m_dbz = 1'b0;
         end
      end
   end

   // Compare DUT against model every cycle outside reset
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", 32'(busy), 32'(m_t >= 1 && m_t <= 33));
         chk("done", 32'(done), 32'(m_t == 34));
         chk("lo", lo, m_lo);
         chk("hi", hi, m_hi);
         chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      end
   end

   // Directed op: start in cycle 0, then wait for done with a bound
   task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                     input logic edbz, input string name);
      int n, nb;
      @(negedge clk);
      opa = a; opb = b; signed_div = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0; opa = $urandom; opb = $urandom; signed_div = ~s;
      n = 1; nb = 0;
      while (!done && n < 60) begin
         if (busy) nb++;
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, 32'(n), 32'(exp_lat));
      chk({name, "_busy_cycles"}, 32'(nb), 32'(exp_lat - 1));
      chk({name, "_lo"}, lo, eq);
      chk({name, "_hi"}, hi, er);
      chk({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 8)
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return $urandom % 100;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n, cnt_d, cnt_b;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      op(32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 1'b0, "u100_7");
      op(32'hFFFF_FFF9, 32'd2, 1'b1, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "s_m7_2");
      op(32'hFFFF_FFF9, 32'd2, 1'b0, 34, 32'h7FFF_FFFC, 32'd1, 1'b0, "u_fff9_2");
      op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, 32'h8000_0000, 32'd0, 1'b0, "s_ovf");
      op(32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1, "div0");
      op(32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 1'b0, "dbz_clear");

      // Annul at cycle 10
      @(negedge clk);
      opa = 32'd200; opb = 32'd3; signed_div = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      chk("annul_busy_c11", 32'(busy), 32'd0);
      cnt_d = 0;
      repeat (40) begin
         if (done) cnt_d++;
         @(negedge clk);
      end
      chk("annul_no_done", 32'(cnt_d), 32'd0);
      chk("annul_lo_kept", lo, 32'd14);
      chk("annul_hi_kept", hi, 32'd2);

      // Annul together with start in IDLE
      opa = 32'd9; opb = 32'd3; start = 1'b1; annul = 1'b1;
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      cnt_b = 0; cnt_d = 0;
      repeat (5) begin
         if (busy) cnt_b++;
         if (done) cnt_d++;
         @(negedge clk);
      end
      chk("annul_start_busy", 32'(cnt_b), 32'd0);
      chk("annul_start_done", 32'(cnt_d), 32'd0);

      // Start re-asserted in cycles 5-20, then back-to-back start in the done cycle
      opa = 32'd1000; opb = 32'd10; signed_div = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 60) begin
         start = (n >= 5 && n <= 20);
         opa = 32'd77; opb = 32'd5;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("ignore_start_latency", 32'(n), 32'd34);
      chk("ignore_start_lo", lo, 32'd100);
      chk("ignore_start_hi", hi, 32'd0);
      opa = 32'd50; opb = 32'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
      chk("b2b_done_falls", 32'(done), 32'd0);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_latency", 32'(n), 32'd68);
      chk("b2b_lo", lo, 32'd6);
      chk("b2b_hi", hi, 32'd2);

      // Reset pulsed at cycle 20 of an operation
      @(negedge clk);
      opa = 32'd300; opb = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_lo", lo, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      op(32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 1'b0, "post_rst");

      // Random traffic, checked cycle by cycle against the model
      cnt_d = 0;
      for (int i = 0; i < 2000; i++) begin
         start      = ($urandom % 4 == 0);
         annul      = ($urandom % 80 == 0);
         signed_div = $urandom % 2;
         opa        = pick();
         opb        = pick();
         @(negedge clk);
         if (done) cnt_d++;
      end
      start = 1'b0; annul = 1'b0;
      repeat (40) @(negedge clk);
      chk("random_done_seen", 32'(cnt_d >= 5), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and SHALL name these ports clk and rst.
REQ-002 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  async active-high reset.
REQ-005 Port: start  input  1  request a new division; sampled on rising edge.
REQ-006 Port: signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-007 Port: opa  input  32  dividend (register-file read port 1).
REQ-008 Port: opb  input  32  divisor (register-file read port 2).
REQ-009 Port: annul  input  1  abort the in-flight operation (pipeline flush).
REQ-010 Port: busy  output  1  high while state is CALC or FIX.
REQ-011 Port: done  output  1  one-cycle pulse; hi/lo/div_by_zero valid from this cycle.
REQ-012 Port: lo  output  32  quotient.
REQ-013 Port: hi  output  32  remainder.
REQ-014 Port: div_by_zero  output  1  last completed operation had opb = 0.

Function
REQ-015 States SHALL be IDLE, CALC, FIX and DONE; busy and done SHALL be decoded directly from state.
REQ-016 In IDLE or DONE, start=1 with annul=0 SHALL capture opa, opb and signed_div; later input changes SHALL be ignored.
REQ-017 Start with captured opb != 0 SHALL enter CALC; start with opb = 0 SHALL enter DONE directly.
REQ-018 Start while busy=1 SHALL be ignored, with no queuing.
REQ-019 CALC SHALL run exactly 32 cycles of restoring radix-2 division on the operand magnitudes, one quotient bit per cycle, using a 6-bit iteration counter; it SHALL then enter FIX.
REQ-020 FIX SHALL take 1 cycle: negate the quotient if signed_div and the operand signs differ, and negate the remainder if signed_div and the dividend is negative; it SHALL then enter DONE.
REQ-021 Latency: start sampled at the end of cycle 0 -> busy high in cycles 1-33 -> done high in cycle 34 only.
REQ-022 hi, lo and div_by_zero SHALL load only on entry to DONE and SHALL hold until the next completed operation.
REQ-023 For signed 0x80000000 / 0xFFFFFFFF the block SHALL produce lo = 0x80000000 and hi = 0 with no exception.
REQ-024 For division by zero the block SHALL produce lo = 0xFFFFFFFF, hi = opa and div_by_zero = 1, with done in cycle 1.
REQ-025 div_by_zero SHALL clear on the next completed operation with opb != 0.
REQ-026 annul=1 in CALC, FIX or DONE SHALL force IDLE on the next edge, with no done pulse and hi/lo/div_by_zero unchanged.
REQ-027 annul SHALL take priority over a simultaneous start, and the start SHALL be dropped.
REQ-028 start=1 in the DONE cycle SHALL begin a new operation back-to-back, and done SHALL fall in the next cycle.
REQ-029 The internal remainder/quotient datapath SHALL be 33/32 bits with no carry loss; magnitude of 0x80000000 SHALL be treated as unsigned 2^31.

Reset
REQ-030 rst=1 SHALL immediately, asynchronously, force state IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0.
REQ-031 Reset asserted mid-operation SHALL discard the operation; after release, the first start SHALL behave as from power-up.

Verification
REQ-032 Unsigned: opa=100, opb=7, start cycle 0 -> done cycle 34, lo=14, hi=2, div_by_zero=0; busy high cycles 1-33.
REQ-033 Signed: opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; the same operands unsigned -> lo=0x7FFFFFFC, hi=1.
REQ-034 Edge cases: signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; opa=5, opb=0 -> done cycle 1, lo=0xFFFFFFFF, hi=5, div_by_zero=1.
REQ-035 Annul at cycle 10 -> busy=0 from cycle 11, no done for 40 cycles, hi/lo keep prior values; annul together with start in IDLE -> nothing starts.
REQ-036 Start re-asserted in cycles 5-20 is ignored; start in the DONE cycle (34) -> second done at cycle 68 with second-operand results.
REQ-037 rst pulsed at cycle 20 of an operation -> all outputs 0 in the same cycle; a new 100/7 after release -> lo=14 after 34 cycles.
